// File: rtl/processor_selector.sv
// Opcode-driven router between the shared front end and the linear/circular
// motion sub-processors; all outputs are registered (1-cycle latency).
//
// Ports:
//   clk, reset (async, active-low)
//   op                       opcode selecting LIN (G00/G01), CIRC (G02/G03)
//                            or NONE (anything else)
//   trigger_in, stepper_done_in       strobes steered to the selected unit
//   lin_*_in / circ_*_in     sub-processor results (steps, servo, done)
//   lin_*_out / circ_*_out   steered strobes
//   num_steps_x/y_out, servo_pos_out, done_out   selected results
module processor_selector #(
    parameter int OP_BITS        = 4,
    parameter int STEPPER_X_BITS = 16,
    parameter int STEPPER_Y_BITS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [OP_BITS-1:0]        op,
    input  logic                      trigger_in,
    input  logic                      stepper_done_in,
    input  logic [STEPPER_X_BITS-1:0] lin_num_steps_x_in,
    input  logic [STEPPER_Y_BITS-1:0] lin_num_steps_y_in,
    input  logic                      lin_servo_pos_in,
    input  logic                      lin_done_in,
    input  logic [STEPPER_X_BITS-1:0] circ_num_steps_x_in,
    input  logic [STEPPER_Y_BITS-1:0] circ_num_steps_y_in,
    input  logic                      circ_servo_pos_in,
    input  logic                      circ_done_in,
    output logic                      lin_trigger_out,
    output logic                      lin_stepper_done_out,
    output logic                      circ_trigger_out,
    output logic                      circ_stepper_done_out,
    output logic [STEPPER_X_BITS-1:0] num_steps_x_out,
    output logic [STEPPER_Y_BITS-1:0] num_steps_y_out,
    output logic                      servo_pos_out,
    output logic                      done_out
);

    localparam logic [OP_BITS-1:0] OP_G00 = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_G01 = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_G02 = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_G03 = OP_BITS'(3);

    localparam logic SERVO_POS_UP   = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LIN,
        SEL_CIRC
    } sel_t;

    sel_t sel;

    logic                      lin_trig_d;
    logic                      lin_sdone_d;
    logic                      circ_trig_d;
    logic                      circ_sdone_d;
    logic [STEPPER_X_BITS-1:0] steps_x_d;
    logic [STEPPER_Y_BITS-1:0] steps_y_d;
    logic                      servo_d;
    logic                      done_d;

    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            (op == OP_G00) || (op == OP_G01): sel = SEL_LIN;
            (op == OP_G02) || (op == OP_G03): sel = SEL_CIRC;
            default:                          sel = SEL_NONE;
        endcase
    end

    always_comb begin
        lin_trig_d   = 1'b0;
        lin_sdone_d  = 1'b0;
        circ_trig_d  = 1'b0;
        circ_sdone_d = 1'b0;
        steps_x_d    = '0;
        steps_y_d    = '0;
        servo_d      = SERVO_POS_UP;
        // Unsupported ops report done so the dispatcher never stalls.
        done_d       = 1'b1;
        unique case (sel)
            SEL_LIN: begin
                lin_trig_d  = trigger_in;
                lin_sdone_d = stepper_done_in;
                steps_x_d   = lin_num_steps_x_in;
                steps_y_d   = lin_num_steps_y_in;
                servo_d     = lin_servo_pos_in;
                done_d      = lin_done_in;
            end
            SEL_CIRC: begin
                circ_trig_d  = trigger_in;
                circ_sdone_d = stepper_done_in;
                steps_x_d    = circ_num_steps_x_in;
                steps_y_d    = circ_num_steps_y_in;
                servo_d      = circ_servo_pos_in;
                done_d       = circ_done_in;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lin_trigger_out       <= 1'b0;
            lin_stepper_done_out  <= 1'b0;
            circ_trigger_out      <= 1'b0;
            circ_stepper_done_out <= 1'b0;
            num_steps_x_out       <= '0;
            num_steps_y_out       <= '0;
            servo_pos_out         <= SERVO_POS_UP;
            done_out              <= 1'b0;
        end else begin
            lin_trigger_out       <= lin_trig_d;
            lin_stepper_done_out  <= lin_sdone_d;
            circ_trigger_out      <= circ_trig_d;
            circ_stepper_done_out <= circ_sdone_d;
            num_steps_x_out       <= steps_x_d;
            num_steps_y_out       <= steps_y_d;
            servo_pos_out         <= servo_d;
            done_out              <= done_d;
        end
    end

endmodule

// File: tb/tb_processor_selector.sv
// Randomized + directed bench for processor_selector against an
// opcode-rule reference model.
module tb_processor_selector;

    localparam logic [3:0] G00 = 4'd0;
    localparam logic [3:0] G01 = 4'd1;
    localparam logic [3:0] G02 = 4'd2;
    localparam logic [3:0] G03 = 4'd3;
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        trigger_in, stepper_done_in;
    logic [15:0] lx, ly, cx, cy;
    logic        lsv, ldn, csv, cdn;
    logic        lin_trig, lin_sdone, circ_trig, circ_sdone;
    logic [15:0] sx, sy;
    logic        servo, done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        lt, ls, ct, cs;
        logic [15:0] x, y;
        logic        sv, dn;
    } exp_t;

    exp_t e;

    always #5 clk = ~clk;

    processor_selector dut (
        .clk(clk), .reset(reset), .op(op),
        .trigger_in(trigger_in), .stepper_done_in(stepper_done_in),
        .lin_num_steps_x_in(lx), .lin_num_steps_y_in(ly),
        .lin_servo_pos_in(lsv), .lin_done_in(ldn),
        .circ_num_steps_x_in(cx), .circ_num_steps_y_in(cy),
        .circ_servo_pos_in(csv), .circ_done_in(cdn),
        .lin_trigger_out(lin_trig), .lin_stepper_done_out(lin_sdone),
        .circ_trigger_out(circ_trig),
        .circ_stepper_done_out(circ_sdone),
        .num_steps_x_out(sx), .num_steps_y_out(sy),
        .servo_pos_out(servo), .done_out(done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference: what the outputs should show one edge after these inputs.
    function automatic exp_t model();
        exp_t r;
        r = '{lt: 0, ls: 0, ct: 0, cs: 0, x: 0, y: 0, sv: UP, dn: 1};
        if (op inside {G00, G01}) begin
            r.lt = trigger_in; r.ls = stepper_done_in;
            r.x = lx; r.y = ly; r.sv = lsv; r.dn = ldn;
        end else if (op inside {G02, G03}) begin
            r.ct = trigger_in; r.cs = stepper_done_in;
            r.x = cx; r.y = cy; r.sv = csv; r.dn = cdn;
        end
        return r;
    endfunction

    task automatic check_all(input exp_t x, input string tag);
        check({tag, ".lin_trig"},   32'(lin_trig),   32'(x.lt));
        check({tag, ".lin_sdone"},  32'(lin_sdone),  32'(x.ls));
        check({tag, ".circ_trig"},  32'(circ_trig),  32'(x.ct));
        check({tag, ".circ_sdone"}, 32'(circ_sdone), 32'(x.cs));
        check({tag, ".x"},          32'(sx),         32'(x.x));
        check({tag, ".y"},          32'(sy),         32'(x.y));
        check({tag, ".servo"},      32'(servo),      32'(x.sv));
        check({tag, ".done"},       32'(done),       32'(x.dn));
        check({tag, ".excl"}, 32'(lin_trig & circ_trig), 32'(0));
    endtask

    // Capture expectation, cross one rising edge, sample 1ns later.
    task automatic step(input string tag);
        e = model();
        @(posedge clk);
        #1;
        check_all(e, tag);
    endtask

    task automatic static_inputs();
        trigger_in = 1; stepper_done_in = 1;
        lx = 16'd4; ly = 16'hFFFD; lsv = UP;   ldn = 1;
        cx = 16'd5; cy = 16'd6;    csv = DOWN; cdn = 0;
    endtask

    exp_t rst_exp;

    initial begin
        rst_exp = '{lt: 0, ls: 0, ct: 0, cs: 0, x: 0, y: 0, sv: UP, dn: 0};
        reset = 0;
        op = G00;
        static_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all(rst_exp, "reset");
        reset = 1;

        op = G00;
        for (int i = 0; i < 10; i++) step("g00");
        check(".g00_y_neg3", 32'(sy), 32'h0000FFFD);
        op = G02;
        step("g02");
        check(".g02_servo_down", 32'(servo), 32'(DOWN));
        op = G01;
        for (int i = 0; i < 10; i++) step("g01");
        op = G03;
        for (int i = 0; i < 10; i++) step("g03");
        op = 4'd9;
        for (int i = 0; i < 3; i++) step("none");

        // Mid-operation asynchronous reset.
        op = G02;
        step("pre_rst");
        #2;
        reset = 0;
        #1;
        check_all(rst_exp, "async_rst");
        @(negedge clk);
        reset = 1;
        step("rst_release");

        // Trigger toggling under G01.
        op = G01;
        for (int i = 0; i < 8; i++) begin
            trigger_in = i[0];
            step("toggle");
        end

        // Randomized traffic, biased toward the defined opcodes.
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                              : 4'($urandom_range(0, 3));
            trigger_in      = 1'($urandom);
            stepper_done_in = 1'($urandom);
            lx  = 16'($urandom); ly  = 16'($urandom);
            cx  = 16'($urandom); cy  = 16'($urandom);
            lsv = 1'($urandom);  ldn = 1'($urandom);
            csv = 1'($urandom);  cdn = 1'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/processor_selector.md
Name: processor_selector

Overview:
- Opcode-driven router between the shared processor front end and the two motion sub-processors: linear (G00/G01) and circular (G02/G03).
- Steers trigger and stepper-done strobes to the selected sub-processor.
- Multiplexes the selected sub-processor's step counts, servo position and done flag back to the shared outputs.
- Sits between the opcode decoder/dispatcher and the stepper/servo drivers.

Parameters:
- OP_BITS, 4, width of the op field (Opcode_p::Opcode_t).
- STEPPER_X_BITS, 16, width of the signed two's-complement X step count.
- STEPPER_Y_BITS, 16, width of the signed two's-complement Y step count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  OP_BITS  current opcode (Opcode_p::Opcode_t).
- trigger_in  in  1  start strobe from the dispatcher.
- stepper_done_in  in  1  stepper-finished indication from the stepper drivers.
- lin_num_steps_x_in  in  STEPPER_X_BITS  linear-processor X steps.
- lin_num_steps_y_in  in  STEPPER_Y_BITS  linear-processor Y steps.
- lin_servo_pos_in  in  Servo_p::ServoPosition_t  linear-processor servo request.
- lin_done_in  in  1  linear-processor done.
- circ_num_steps_x_in  in  STEPPER_X_BITS  circular-processor X steps.
- circ_num_steps_y_in  in  STEPPER_Y_BITS  circular-processor Y steps.
- circ_servo_pos_in  in  Servo_p::ServoPosition_t  circular-processor servo request.
- circ_done_in  in  1  circular-processor done.
- lin_trigger_out  out  1  trigger to the linear processor.
- lin_stepper_done_out  out  1  stepper-done to the linear processor.
- circ_trigger_out  out  1  trigger to the circular processor.
- circ_stepper_done_out  out  1  stepper-done to the circular processor.
- num_steps_x_out  out  STEPPER_X_BITS  selected X steps.
- num_steps_y_out  out  STEPPER_Y_BITS  selected Y steps.
- servo_pos_out  out  Servo_p::ServoPosition_t  selected servo position.
- done_out  out  1  selected done.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- Decode of op against Opcode_p constants:
  - OP_G00 or OP_G01 -> LIN.
  - OP_G02 or OP_G03 -> CIRC.
  - Any other value -> NONE.
- All outputs are registered. Each output reflects the inputs sampled at the previous rising clk edge (1-cycle latency). No other state is held.
- LIN:
  - lin_trigger_out = trigger_in; lin_stepper_done_out = stepper_done_in.
  - circ_trigger_out = 0; circ_stepper_done_out = 0.
  - num_steps_x/y_out = lin_num_steps_x/y_in; servo_pos_out = lin_servo_pos_in; done_out = lin_done_in.
- CIRC:
  - The mirror of LIN: circ_* strobes follow trigger_in and stepper_done_in; lin_* strobes are 0.
  - num_steps_x/y_out, servo_pos_out and done_out come from the circ_* inputs.
- NONE:
  - All four trigger/stepper-done outputs are 0.
  - num_steps_x_out = 0; num_steps_y_out = 0; servo_pos_out = SERVO_POS_UP (pen lifted).
  - done_out = 1, so the dispatcher never stalls on an unsupported op.
- The non-selected sub-processor never receives a trigger or stepper-done, even when both strobes are 1.
- Step counts pass through bit-exact. No sign extension or truncation; widths are identical on input and output.
- An op change takes effect on the next clk edge. Both strobe paths are re-steered in the same cycle, so no cycle ever drives both lin_trigger_out and circ_trigger_out high.
- Reset state (asserted at any time, including mid-operation):
  - All triggers and stepper-dones 0.
  - num_steps_x/y_out = 0; servo_pos_out = SERVO_POS_UP; done_out = 0.
- After reset deassertion, the outputs follow the decode from the first rising edge onward.

Test Plan:
- Static inputs for all scenarios:
  - trigger_in = 1, stepper_done_in = 1.
  - lin: x = 4, y = -3, servo UP, done = 1.
  - circ: x = 5, y = 6, servo DOWN, done = 0.
- op = OP_G00 held 10 clks -> lin_trigger_out = 1, lin_stepper_done_out = 1, circ strobes 0, x = 4, y = 0xFFFD (-3), servo UP, done_out = 1.
- op = OP_G02 -> one clk later: circ strobes 1, lin strobes 0, x = 5, y = 6, servo DOWN, done_out = 0.
- op = OP_G01 then OP_G03, 10 clks each -> same results as G00 and G02 respectively. Assert lin_trigger_out and circ_trigger_out are never both 1.
- op = undefined encoding -> all strobes 0, steps 0, servo UP, done_out = 1.
- Assert reset mid-G02 -> outputs go to the reset values immediately, without waiting for a clk edge. Release -> circ routing restored one clk later.
- Toggle trigger_in 0/1 each clk under OP_G01 -> lin_trigger_out follows with 1-clk delay; circ_trigger_out stays 0.
